// File: rtl/inv_rnd_func.sv
// Iterative AES-128 inverse cipher, one round per advance; keys fetched 10..0.
// Define INV_RND_STALL_EN to add the En_Func round-advance gate.
module inv_rnd_func (
  input  logic         CLK,
  input  logic         rst,
  input  logic         Valid,
  input  logic [127:0] Cypher_txt,
  output logic [3:0]   Key_Idx,
  input  logic [127:0] Key_Rnd,
`ifdef INV_RND_STALL_EN
  input  logic         En_Func,
`endif
  output logic         Busy,
  output logic         Done,
  output logic [127:0] Plain_txt
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} st_t;

  st_t          st, st_nx;
  logic [127:0] state, state_nx;
  logic [127:0] plain_nx;
  logic [3:0]   rnd, rnd_nx;
  logic         done_nx;
  logic         adv;

`ifdef INV_RND_STALL_EN
  assign adv = En_Func;
`else
  assign adv = 1'b1;
`endif

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse affine, then multiplicative inverse as x^254 (0 maps to 0)
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x, sq, r;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_subs_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_rnd_key(input logic [127:0] s,
                                               input logic [127:0] k);
    return s ^ k;
  endfunction

  always_comb begin
    st_nx    = st;
    state_nx = state;
    rnd_nx   = rnd;
    plain_nx = Plain_txt;
    done_nx  = 1'b0;
    Key_Idx  = 4'd10;
    Busy     = 1'b0;
    unique case (st)
      IDLE: begin
        if (Valid) begin
          state_nx = add_rnd_key(Cypher_txt, Key_Rnd);
          rnd_nx   = 4'd9;
          st_nx    = ROUND;
        end
      end
      ROUND: begin
        Key_Idx = rnd;
        Busy    = 1'b1;
        if (adv) begin
          state_nx = inv_mix_cols(add_rnd_key(
                       inv_subs_bytes(inv_shift_rows(state)), Key_Rnd));
          rnd_nx   = rnd - 4'd1;
          if (rnd == 4'd1) st_nx = FINAL;
        end
      end
      FINAL: begin
        Key_Idx = 4'd0;
        Busy    = 1'b1;
        // Last round has no InvMixCols
        if (adv) begin
          plain_nx = add_rnd_key(inv_subs_bytes(inv_shift_rows(state)),
                                 Key_Rnd);
          done_nx  = 1'b1;
          st_nx    = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      st        <= IDLE;
      state     <= '0;
      rnd       <= '0;
      Plain_txt <= '0;
      Done      <= 1'b0;
    end else begin
      st        <= st_nx;
      state     <= state_nx;
      rnd       <= rnd_nx;
      Plain_txt <= plain_nx;
      Done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_inv_rnd_func.sv
// Directed bench for inv_rnd_func with a modelled AES-128 round-key store.
// Define INV_RND_STALL_EN to also run the stall scenario.
module tb_inv_rnd_func;

  logic         CLK;
  logic         rst;
  logic         Valid;
  logic [127:0] Cypher_txt;
  logic [3:0]   Key_Idx;
  logic [127:0] Key_Rnd;
  logic         Busy;
  logic         Done;
  logic [127:0] Plain_txt;
`ifdef INV_RND_STALL_EN
  logic         En_Func;
`endif

  logic [127:0] rk [0:15];
  int ncmp;
  int nfail;
  int done_cnt;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  inv_rnd_func dut (
    .CLK        (CLK),
    .rst        (rst),
    .Valid      (Valid),
    .Cypher_txt (Cypher_txt),
    .Key_Idx    (Key_Idx),
    .Key_Rnd    (Key_Rnd),
`ifdef INV_RND_STALL_EN
    .En_Func    (En_Func),
`endif
    .Busy       (Busy),
    .Done       (Done),
    .Plain_txt  (Plain_txt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign Key_Rnd = rk[Key_Idx];

  always @(negedge CLK) if (Done === 1'b1) done_cnt++;

  function automatic logic [7:0] xtm(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) p ^= x;
      x = xtm(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box: inverse by repeated multiplication, then affine map
  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [7:0] r, s;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gm(r, b);
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
          ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])}
            ^ {rc, 24'h0};
        rc = xtm(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge where Done is expected
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                           input bit inj);
    Valid = 1'b1;
    Cypher_txt = ct;
    chk("idle_idx", 128'(Key_Idx), 128'd10);
    chk("idle_busy", 128'(Busy), 128'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      Valid = 1'b0;
      if (inj && c == 2) begin
        Valid = 1'b1;
        Cypher_txt = ~ct;
      end
      chk("rnd_idx", 128'(Key_Idx), 128'((c < 9) ? 9 - c : 0));
      chk("rnd_busy", 128'(Busy), 128'd1);
      chk("rnd_done", 128'(Done), 128'd0);
    end
    @(negedge CLK);
    Valid = 1'b0;
    chk("done_hi", 128'(Done), 128'd1);
    chk("done_busy", 128'(Busy), 128'd0);
    chk("plain", Plain_txt, pt);
    chk("done_idx", 128'(Key_Idx), 128'd10);
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    done_cnt = 0;
    rst = 1'b1;
    Valid = 1'b0;
    Cypher_txt = '0;
`ifdef INV_RND_STALL_EN
    En_Func = 1'b1;
`endif
    set_key(K_C1);
    repeat (2) @(negedge CLK);
    chk("rst_busy", 128'(Busy), 128'd0);
    chk("rst_done", 128'(Done), 128'd0);
    chk("rst_plain", Plain_txt, 128'd0);
    chk("rst_idx", 128'(Key_Idx), 128'd10);
    rst = 1'b0;
    @(negedge CLK);

    // C.1 vector with a stray Valid while busy, then back-to-back block
    run_block(CT_C1, PT_C1, 1'b1);
    set_key(K_B);
    run_block(CT_B, PT_B, 1'b0);
    @(negedge CLK);
    chk("b2b_done_lo", 128'(Done), 128'd0);
    chk("done_count", 128'(done_cnt), 128'd2);

    // Reset after E4, taking effect at E5
    set_key(K_C1);
    Valid = 1'b1;
    Cypher_txt = CT_C1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      Valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge CLK);
    chk("abort_busy", 128'(Busy), 128'd0);
    chk("abort_plain", Plain_txt, 128'd0);
    chk("abort_idx", 128'(Key_Idx), 128'd10);
    rst = 1'b0;
    repeat (12) @(negedge CLK);
    chk("abort_nodone", 128'(done_cnt), 128'd2);
    run_block(CT_C1, PT_C1, 1'b0);
    @(negedge CLK);

    // All-zero key; Done must be a single-cycle pulse
    set_key('0);
    run_block(CT_Z, 128'd0, 1'b0);
    @(negedge CLK);
    chk("zero_done_lo", 128'(Done), 128'd0);
    chk("zero_count", 128'(done_cnt), 128'd4);

`ifdef INV_RND_STALL_EN
    set_key(K_C1);
    Valid = 1'b1;
    Cypher_txt = CT_C1;
    for (int c = 0; c < 13; c++) begin
      @(negedge CLK);
      Valid = 1'b0;
      if (c >= 2 && c <= 5)
        chk("stall_idx", 128'(Key_Idx), 128'd7);
      chk("stall_busy", 128'(Busy), 128'd1);
      chk("stall_done", 128'(Done), 128'd0);
      En_Func = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
    end
    @(negedge CLK);
    chk("stall_done_hi", 128'(Done), 128'd1);
    chk("stall_plain", Plain_txt, PT_C1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
